// File: rtl/serial_link_obi_arbiter.sv
// rtl/serial_link_obi_arbiter.sv - round-robin OBI arbiter with in-order response steering
// Optional feature macro: SERIAL_LINK_ARB_PERF_CNT_EN (per-requester grant counters)
module serial_link_obi_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_i,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*DataWidth/8-1:0]   be_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    output logic [NumReq-1:0]               gnt_o,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mst_req_o,
    output logic [AddrWidth-1:0]            mst_addr_o,
    output logic                            mst_we_o,
    output logic [DataWidth/8-1:0]          mst_be_o,
    output logic [DataWidth-1:0]            mst_wdata_o,
    input  logic                            mst_gnt_i,
    input  logic                            mst_rvalid_i,
    input  logic [DataWidth-1:0]            mst_rdata_i,
    output logic                            busy_o,
    output logic                            err_o
`ifdef SERIAL_LINK_ARB_PERF_CNT_EN
    ,
    output logic [NumReq*16-1:0]            grant_cnt_o,
    input  logic                            cnt_clr_i
`endif
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = $clog2(NumReq);
    localparam int unsigned PtrW    = $clog2(MaxOutstanding);
    localparam int unsigned CntW    = PtrW + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] sel_rr;
    logic [IdxW-1:0] sel;
    logic            found;
    logic            mst_req;
    logic            hs;
    logic            pop;

    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            err_q;
    logic            full;
    logic            empty;

    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);

    // Rotating priority scan: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        sel_rr = rr_ptr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!found && req_i[IdxW'(idx)]) begin
                found  = 1'b1;
                sel_rr = IdxW'(idx);
            end
        end
    end

    // Next state, forwarding mux and handshake; a pending request pins the selection.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        sel        = sel_rr;
        mst_req    = 1'b0;
        if (state_q == LOCKED) begin
            sel     = lock_idx_q;
            mst_req = req_i[lock_idx_q];
        end else begin
            mst_req = found && !full;
        end
        if (rst_i) begin
            mst_req = 1'b0;
        end
        hs = mst_req && mst_gnt_i;
        if (hs) begin
            state_d = IDLE;
        end else if (mst_req) begin
            state_d    = LOCKED;
            lock_idx_d = sel;
        end else begin
            state_d = IDLE;
        end
    end

    // Downstream and grant outputs are all zero whenever no request is forwarded.
    always_comb begin
        gnt_o       = '0;
        mst_addr_o  = '0;
        mst_we_o    = 1'b0;
        mst_be_o    = '0;
        mst_wdata_o = '0;
        if (hs) begin
            gnt_o[sel] = 1'b1;
        end
        if (mst_req) begin
            mst_addr_o  = addr_i[int'(sel)*AddrWidth +: AddrWidth];
            mst_we_o    = we_i[sel];
            mst_be_o    = be_i[int'(sel)*BeWidth +: BeWidth];
            mst_wdata_o = wdata_i[int'(sel)*DataWidth +: DataWidth];
        end
    end

    assign mst_req_o = mst_req;
    assign pop       = mst_rvalid_i && !empty && !rst_i;

    // Response steering: the oldest outstanding ID owns the incoming response.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (pop) begin
            rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
            rdata_o                    = mst_rdata_i;
        end
    end

    // Control state, round-robin pointer, FIFO pointers/count and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            if (hs) begin
                rr_ptr_q <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (hs && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !hs) begin
                count_q <= count_q - 1'b1;
            end
            if (mst_rvalid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    assign busy_o = !empty;
    assign err_o  = err_q;

`ifdef SERIAL_LINK_ARB_PERF_CNT_EN
    logic [15:0] cnt_q [NumReq];

    // Saturating grant counters; clear wins over a same-cycle grant.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (rst_i || cnt_clr_i) begin
                cnt_q[k] <= '0;
            end else if (gnt_o[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_q[k] <= cnt_q[k] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_cnt_out
        assign grant_cnt_o[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_serial_link_obi_arbiter.sv
// tb/tb_serial_link_obi_arbiter.sv - table, directed and randomized checks for serial_link_obi_arbiter
module tb_serial_link_obi_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      we;
    logic [N*BW-1:0]   be;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              mst_req;
    logic [AW-1:0]     mst_addr;
    logic              mst_we;
    logic [BW-1:0]     mst_be;
    logic [DW-1:0]     mst_wdata;
    logic              mst_gnt;
    logic              mst_rvalid;
    logic [DW-1:0]     mst_rdata;
    logic              busy;
    logic              err;
`ifdef SERIAL_LINK_ARB_PERF_CNT_EN
    logic [N*16-1:0]   grant_cnt;
    logic              cnt_clr;
`endif

    serial_link_obi_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mst_req_o(mst_req), .mst_addr_o(mst_addr), .mst_we_o(mst_we), .mst_be_o(mst_be),
        .mst_wdata_o(mst_wdata), .mst_gnt_i(mst_gnt), .mst_rvalid_i(mst_rvalid),
        .mst_rdata_i(mst_rdata), .busy_o(busy), .err_o(err)
`ifdef SERIAL_LINK_ARB_PERF_CNT_EN
        , .grant_cnt_o(grant_cnt), .cnt_clr_i(cnt_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  req;
        logic        g;
        logic        rv;
        logic [1:0]  egnt;
        logic [1:0]  erv;
        logic        emreq;
        logic [31:0] eaddr;
        logic        ebusy;
    } vec_t;

    vec_t tbl [6];

    int q [$];
    int ptr;
    int lock;
    bit merr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] rd);
        req        = r;
        mst_gnt    = g;
        mst_rvalid = rv;
        mst_rdata  = rd;
    endtask

    task automatic set_default_payload();
        addr  = {32'h0000_2000, 32'h0000_1000};
        we    = 2'b10;
        be    = {4'hC, 4'h3};
        wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic g, input logic rv,
                                input logic [1:0] eg, input logic [1:0] erv,
                                input logic emr, input logic [31:0] ea, input logic eb);
        vec_t v;
        v.req = r; v.g = g; v.rv = rv; v.egnt = eg; v.erv = erv;
        v.emreq = emr; v.eaddr = ea; v.ebusy = eb;
        return v;
    endfunction

    // One directed cycle: drive at the falling edge, compare just after.
    task automatic dcyc(input string tag, input logic [1:0] r, input logic g, input logic rv,
                        input logic [1:0] eg, input logic [1:0] erv, input logic emr,
                        input logic [31:0] ea);
        @(negedge clk);
        drive(r, g, rv, 32'hC0DE_0000 + 32'(vectors));
        #1;
        chk({tag, " gnt"}, 64'(gnt), 64'(eg));
        chk({tag, " rvalid"}, 64'(rvalid), 64'(erv));
        chk({tag, " mst_req"}, 64'(mst_req), 64'(emr));
        chk({tag, " mst_addr"}, 64'(mst_addr), 64'(ea));
    endtask

    initial begin
        logic [31:0] rd;
        logic [N-1:0] r;
        logic g, rv, emr;
        int es;
        logic [N-1:0] eg, erv;
        logic [15:0] c16;

        rst = 1'b1;
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        set_default_payload();
`ifdef SERIAL_LINK_ARB_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Outputs held quiet while reset is asserted, even with requests pending.
        @(negedge clk);
        #1;
        chk("reset mst_req", 64'(mst_req), 64'h0);
        chk("reset gnt", 64'(gnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset err", 64'(err), 64'h0);
        chk("reset rvalid", 64'(rvalid), 64'h0);
        chk("reset rdata", 64'(rdata), 64'h0);
        chk("reset mst_addr", 64'(mst_addr), 64'h0);

        // Alternating grants with responses one cycle later.
        tbl[0] = mk(2'b11, 1, 0, 2'b01, 2'b00, 1, 32'h1000, 0);
        tbl[1] = mk(2'b11, 1, 1, 2'b10, 2'b01, 1, 32'h2000, 1);
        tbl[2] = mk(2'b11, 1, 1, 2'b01, 2'b10, 1, 32'h1000, 1);
        tbl[3] = mk(2'b11, 1, 1, 2'b10, 2'b01, 1, 32'h2000, 1);
        tbl[4] = mk(2'b00, 0, 1, 2'b00, 2'b10, 0, 32'h0,    1);
        tbl[5] = mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0,    0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd = 32'hA5A5_0000 + 32'(i);
            drive(tbl[i].req, tbl[i].g, tbl[i].rv, rd);
            #1;
            chk($sformatf("tbl%0d gnt", i), 64'(gnt), 64'(tbl[i].egnt));
            chk($sformatf("tbl%0d rvalid", i), 64'(rvalid), 64'(tbl[i].erv));
            chk($sformatf("tbl%0d mst_req", i), 64'(mst_req), 64'(tbl[i].emreq));
            chk($sformatf("tbl%0d mst_addr", i), 64'(mst_addr), 64'(tbl[i].eaddr));
            chk($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].ebusy));
            chk($sformatf("tbl%0d rdata", i), 64'(rdata), (tbl[i].erv != 0) ? 64'(rd) : 64'h0);
        end

        // Pending request on requester 1 pins the address until granted.
        do_reset();
        addr[AW +: AW] = 32'h100;
        dcyc("lock c1", 2'b10, 0, 0, 2'b00, 2'b00, 1, 32'h100);
        dcyc("lock c2", 2'b11, 0, 0, 2'b00, 2'b00, 1, 32'h100);
        dcyc("lock c3", 2'b11, 0, 0, 2'b00, 2'b00, 1, 32'h100);
        dcyc("lock c4", 2'b11, 1, 0, 2'b10, 2'b00, 1, 32'h100);
        dcyc("lock c5", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        dcyc("lock c6", 2'b00, 0, 1, 2'b00, 2'b10, 0, 32'h0);
        dcyc("lock c7", 2'b00, 0, 1, 2'b00, 2'b01, 0, 32'h0);

        // Locked requester drops its request: no hang, arbitration resumes.
        do_reset();
        dcyc("drop c1", 2'b10, 0, 0, 2'b00, 2'b00, 1, 32'h100);
        dcyc("drop c2", 2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        dcyc("drop c3", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        set_default_payload();

        // FIFO full blocks the request even when a response pops the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) dcyc("fill", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        dcyc("full", 2'b01, 1, 0, 2'b00, 2'b00, 0, 32'h0);
        chk("full busy", 64'(busy), 64'h1);
        dcyc("full pop", 2'b01, 1, 1, 2'b00, 2'b01, 0, 32'h0);
        dcyc("full resume", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        for (int i = 0; i < 4; i++) dcyc("drain", 2'b00, 0, 1, 2'b00, 2'b01, 0, 32'h0);

        // Stray response with an empty FIFO sets a sticky error.
        dcyc("stray", 2'b00, 0, 1, 2'b00, 2'b00, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            dcyc("stray after", 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
            chk("err sticky", 64'(err), 64'h1);
        end
        do_reset();
        #1;
        chk("err cleared", 64'(err), 64'h0);

        // Reset with two transactions outstanding drops them; late response flags error.
        dcyc("rst out", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        dcyc("rst out", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        do_reset();
        #1;
        chk("rst out busy", 64'(busy), 64'h0);
        chk("rst out err", 64'(err), 64'h0);
        dcyc("late rsp", 2'b00, 0, 1, 2'b00, 2'b00, 0, 32'h0);
        dcyc("late rsp after", 2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        chk("late rsp err", 64'(err), 64'h1);

`ifdef SERIAL_LINK_ARB_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) dcyc("cnt", 2'b01, 1, 0, 2'b01, 2'b00, 1, 32'h1000);
        dcyc("cnt idle", 2'b00, 0, 1, 2'b00, 2'b01, 0, 32'h0);
        c16 = grant_cnt[15:0];
        chk("grant_cnt0", 64'(c16), 64'd3);
        c16 = grant_cnt[31:16];
        chk("grant_cnt1", 64'(c16), 64'd0);
        @(negedge clk);
        cnt_clr = 1'b1;
        drive(2'b01, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        cnt_clr = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        #1;
        c16 = grant_cnt[15:0];
        chk("grant_cnt clr", 64'(c16), 64'd0);
`else
        c16 = 16'h0;
`endif

        // Randomized traffic against a queue-based reference model.
        do_reset();
        q.delete();
        ptr  = 0;
        lock = -1;
        merr = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (k != lock) begin
                    addr[k*AW +: AW]  = $urandom;
                    we[k]             = 1'($urandom);
                    be[k*BW +: BW]    = 4'($urandom);
                    wdata[k*DW +: DW] = $urandom;
                end
            end
            r = N'($urandom);
            if (lock >= 0 && $urandom_range(0, 15) != 0) r[lock] = 1'b1;
            g  = ($urandom_range(0, 3) != 0);
            rv = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            rd = $urandom;
            drive(r, g, rv, rd);
            #1;
            es  = 0;
            emr = 1'b0;
            if (lock >= 0) begin
                es  = lock;
                emr = r[lock];
            end else if (q.size() < MO) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (r[(ptr + i) % N]) begin
                        es  = (ptr + i) % N;
                        emr = 1'b1;
                    end
                end
            end
            eg  = (emr && g) ? N'(1 << es) : '0;
            erv = (rv && q.size() > 0) ? N'(1 << q[0]) : '0;
            chk("rnd gnt", 64'(gnt), 64'(eg));
            chk("rnd rvalid", 64'(rvalid), 64'(erv));
            chk("rnd mst_req", 64'(mst_req), 64'(emr));
            chk("rnd busy", 64'(busy), 64'(q.size() != 0));
            chk("rnd err", 64'(err), 64'(merr));
            chk("rnd rdata", 64'(rdata), (erv != 0) ? 64'(rd) : 64'h0);
            if (emr) begin
                chk("rnd mst_addr", 64'(mst_addr), 64'(addr[es*AW +: AW]));
                chk("rnd mst_payload", 64'({mst_we, mst_be, mst_wdata}),
                    64'({we[es], be[es*BW +: BW], wdata[es*DW +: DW]}));
            end
            if (rv) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1'b1;
            end
            if (emr && g) begin
                q.push_back(es);
                ptr  = (es + 1) % N;
                lock = -1;
            end else if (emr) begin
                lock = es;
            end else begin
                lock = -1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_link_obi_arbiter.md
Name: serial_link_obi_arbiter

Overview:
- Round-robin arbiter that shares the serial link's single OBI slave port between NumReq OBI requesters (e.g. core data port and DMA).
- Sits in front of the OBI-to-AXI-Lite bridge that feeds the serial link AXI input.
- Tracks outstanding transactions in an in-order ID FIFO, so each response is steered back to the requester that issued it.
- Holds the address phase stable while a downstream grant is pending, as OBI requires.

Parameters:
- NumReq, 2, number of upstream OBI requesters (2..8).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.
- MaxOutstanding, 4, depth of the ID FIFO, i.e. the maximum number of granted transactions awaiting rvalid (power of two, at least 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NumReq  per-requester OBI req
- addr_i  in  NumReq*AddrWidth  packed addresses; requester k occupies slice k
- we_i  in  NumReq  write enables
- be_i  in  NumReq*DataWidth/8  byte enables
- wdata_i  in  NumReq*DataWidth  write data
- gnt_o  out  NumReq  per-requester grant
- rvalid_o  out  NumReq  per-requester response valid
- rdata_o  out  DataWidth  response data, shared by all requesters; qualified by rvalid_o
- mst_req_o  out  1  downstream req
- mst_addr_o  out  AddrWidth  downstream address
- mst_we_o  out  1  downstream write enable
- mst_be_o  out  DataWidth/8  downstream byte enable
- mst_wdata_o  out  DataWidth  downstream write data
- mst_gnt_i  in  1  downstream grant
- mst_rvalid_i  in  1  downstream response valid
- mst_rdata_i  in  DataWidth  downstream response data
- busy_o  out  1  high while the ID FIFO is non-empty
- err_o  out  1  sticky flag: mst_rvalid_i seen with an empty ID FIFO

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - rr_ptr=0, ID FIFO empty, lock clear, err_o=0.
  - All outputs 0.
  - A transaction in flight during reset is dropped; a late mst_rvalid_i after reset sets err_o.
- State machine, two states:
  - IDLE: no lock.
  - LOCKED: a downstream req is held without grant; the locked index is stored in lock_idx.
- Arbitration in IDLE:
  - Candidates are requesters with req_i=1.
  - Pick the first candidate scanning from rr_ptr upward, modulo NumReq. Selection is combinational in the same cycle.
  - If the FIFO is full, mst_req_o=0 and no gnt_o is asserted. This holds even if mst_rvalid_i pops the FIFO in the same cycle.
- Forwarding:
  - mst_req_o=1 and mst_addr/we/be/wdata come from the selected requester.
  - gnt_o[sel] = mst_gnt_i & mst_req_o. gnt_o is combinational, zero added latency.
- Handshake (mst_req_o & mst_gnt_i):
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod NumReq.
  - State becomes IDLE.
- Downstream request without grant:
  - Move to LOCKED with lock_idx=sel.
  - While LOCKED, only lock_idx is forwarded, regardless of other requesters.
  - mst_req_o is driven by req_i[lock_idx]. OBI-compliant requesters keep it high, so the lock persists until grant.
  - If req_i[lock_idx] drops anyway (protocol violation), mst_req_o=0 and the block returns to IDLE. It does not hang.
- Response path:
  - On mst_rvalid_i with the FIFO non-empty: rvalid_o[head]=1, rdata_o=mst_rdata_i, pop. Combinational, zero latency.
  - On mst_rvalid_i with the FIFO empty: set err_o, assert no rvalid_o.
  - err_o clears only on reset.
- Simultaneous push and pop with FIFO not full: both happen, and the count is unchanged.
- A response may arrive in the cycle after grant; it may not arrive in the grant cycle itself.
- FIFO pointers are $clog2(MaxOutstanding) bits, wrap naturally, and use a separate count register.
- busy_o = (count != 0), registered.

Optional Feature:
- Macro: SERIAL_LINK_ARB_PERF_CNT_EN.
- When defined:
  - Adds output grant_cnt_o, NumReq*16 bits: per-requester 16-bit saturating counters, incremented on each gnt_o pulse, reset to 0.
  - Adds input cnt_clr_i, 1 bit: synchronous clear of all counters. Clear has priority over a same-cycle increment.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then req_i=2'b11, mst_gnt_i=1 every cycle, responses one cycle later -> grants alternate 0,1,0,1; each rvalid_o pulse matches the requester granted one cycle earlier; rdata_o equals mst_rdata_i.
- req_i[1]=1 at addr 0x100 with mst_gnt_i=0 for 3 cycles, req_i[0] raised in cycle 2 -> mst_addr_o stays 0x100 and no gnt_o[0] until req 1 is granted; req 0 is granted on the next handshake.
- MaxOutstanding=4, 4 grants, no rvalid -> 5th request: mst_req_o=0 and busy_o=1; one rvalid -> mst_req_o re-asserts next cycle.
- mst_rvalid_i=1 with the FIFO empty -> err_o=1 and stays high; no rvalid_o; cleared only by rst_i.
- rst_i asserted with 2 transactions outstanding -> busy_o=0 and all outputs 0 the next cycle; a late mst_rvalid_i sets err_o.
- With SERIAL_LINK_ARB_PERF_CNT_EN: 3 grants to requester 0 -> grant_cnt_o[15:0]=3; cnt_clr_i in the same cycle as a grant -> 0.
